// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS9 constants, state encoding and predictor helper
package prbs_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } prbs_state_e;

   localparam int         PRBS9_TAP_A = 8;
   localparam int         PRBS9_TAP_B = 4;
   localparam int         PRBS9_LEN   = 511;
   localparam logic [8:0] PRBS9_SEED  = 9'h1FF;

   // Next PRBS9 bit from a 9-bit history whose bit 0 is the newest sample.
   function automatic logic prbs9_predict(input logic [8:0] hist);
      return hist[PRBS9_TAP_A] ^ hist[PRBS9_TAP_B];
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - width-parameterized saturating counter with clear and increment
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Clear has priority; otherwise count up and stick at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/prbs9_checker.sv
// rtl/prbs9_checker.sv - self-synchronizing PRBS9 checker with BER counters and loss-of-lock
module prbs9_checker #(
   parameter int CNT_W      = 32,
   parameter int VERIFY_LEN = 16,
   parameter int WIN_LEN    = 64,
   parameter int LOSS_THR   = 8
) (
   input  logic             clk,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic             i_valid,
   input  logic             i_bit,
   output logic             o_lock,
   output logic             o_err,
   output logic [CNT_W-1:0] o_bit_cnt,
   output logic [CNT_W-1:0] o_err_cnt
);

   import prbs_pkg::*;

   localparam int MATCH_W = $clog2(VERIFY_LEN + 1);
   localparam int WIN_W   = $clog2(WIN_LEN + 1);

   prbs_state_e        state_q, state_d;
   logic [8:0]         h_q, h_d;
   logic [3:0]         fill_q, fill_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
   logic [WIN_W-1:0]   win_err_q, win_err_d;
   logic               err_q, err_d;
   logic               pred;
   logic               mis;
   logic               bit_inc;
   logic               err_inc;

   // Sync/verify/flywheel next-state logic; disable overrides everything.
   always_comb begin
      state_d   = state_q;
      h_d       = h_q;
      fill_d    = fill_q;
      match_d   = match_q;
      win_cnt_d = win_cnt_q;
      win_err_d = win_err_q;
      err_d     = 1'b0;
      bit_inc   = 1'b0;
      err_inc   = 1'b0;
      pred      = prbs9_predict(h_q);
      mis       = i_bit ^ pred;

      if (!i_en) begin
         state_d   = SEARCH;
         h_d       = '0;
         fill_d    = '0;
         match_d   = '0;
         win_cnt_d = '0;
         win_err_d = '0;
      end else if (i_valid) begin
         case (state_q)
            SEARCH: begin
               h_d    = {h_q[7:0], i_bit};
               fill_d = fill_q + 4'd1;
               if (fill_d == 4'd9) begin
                  state_d = VERIFY;
                  fill_d  = '0;
                  match_d = '0;
               end
            end
            VERIFY: begin
               h_d = {h_q[7:0], i_bit};
               if (mis) begin
                  match_d = '0;
               end else begin
                  match_d = match_q + 1'b1;
                  if (match_d == MATCH_W'(VERIFY_LEN)) begin
                     // An all-zero history predicts zeros forever; refuse to lock on it.
                     if (h_d != 9'd0) begin
                        state_d   = LOCKED;
                        win_cnt_d = '0;
                        win_err_d = '0;
                     end
                     match_d = '0;
                  end
               end
            end
            LOCKED: begin
               // Flywheel: feed back the prediction so a channel error is counted once.
               h_d       = {h_q[7:0], pred};
               bit_inc   = 1'b1;
               err_inc   = mis;
               err_d     = mis;
               win_cnt_d = win_cnt_q + 1'b1;
               win_err_d = win_err_q + WIN_W'(mis);
               if (win_cnt_d == WIN_W'(WIN_LEN)) begin
                  if (win_err_d >= WIN_W'(LOSS_THR)) begin
                     state_d = SEARCH;
                     fill_d  = '0;
                  end
                  win_cnt_d = '0;
                  win_err_d = '0;
               end
            end
            default: begin
               state_d = SEARCH;
               fill_d  = '0;
            end
         endcase
      end
   end

   // State, history and window registers.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= SEARCH;
         h_q       <= '0;
         fill_q    <= '0;
         match_q   <= '0;
         win_cnt_q <= '0;
         win_err_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         h_q       <= h_d;
         fill_q    <= fill_d;
         match_q   <= match_d;
         win_cnt_q <= win_cnt_d;
         win_err_q <= win_err_d;
         err_q     <= err_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_bit_cnt (
      .clk   (clk),
      .rst_i (i_reset),
      .clr_i (~i_en),
      .inc_i (bit_inc),
      .cnt_o (o_bit_cnt)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_i (i_reset),
      .clr_i (~i_en),
      .inc_i (err_inc),
      .cnt_o (o_err_cnt)
   );

   assign o_lock = (state_q == LOCKED);
   assign o_err  = err_q;

endmodule

// File: tb/tb_prbs9_checker.sv
// tb/tb_prbs9_checker.sv - scoreboard bench for prbs9_checker
module tb_prbs9_checker;

   localparam int EV_RISE = 0;
   localparam int EV_FALL = 1;
   localparam int EV_ERR  = 2;

   typedef struct {
      int kind;
      int cyc;
      int cnt;
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        a_en, a_valid, a_bit, a_lock, a_err;
   logic [31:0] a_bit_cnt, a_err_cnt;
   logic        b_en, b_valid, b_bit, b_lock, b_err;
   logic [3:0]  b_bit_cnt, b_err_cnt;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         a_errs;
   logic [8:0] ga, gb;
   ev_t        exp_q[$];
   logic       lock_prev;
   bit         mon_en;

   prbs9_checker u_dut_a (
      .clk       (clk),
      .i_reset   (rst),
      .i_en      (a_en),
      .i_valid   (a_valid),
      .i_bit     (a_bit),
      .o_lock    (a_lock),
      .o_err     (a_err),
      .o_bit_cnt (a_bit_cnt),
      .o_err_cnt (a_err_cnt)
   );

   prbs9_checker #(.CNT_W(4)) u_dut_b (
      .clk       (clk),
      .i_reset   (rst),
      .i_en      (b_en),
      .i_valid   (b_valid),
      .i_bit     (b_bit),
      .o_lock    (b_lock),
      .o_err     (b_err),
      .o_bit_cnt (b_bit_cnt),
      .o_err_cnt (b_err_cnt)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint got, input longint exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic push(input int kind, input int c, input int cnt);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.cnt  = cnt;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input int cnt);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", kind, e.kind);
         check("event_cycle", cyc, e.cyc);
         if (e.cnt >= 0) check("event_err_cnt", cnt, e.cnt);
      end
   endtask

   // Monitor: every o_err high cycle and every o_lock change must match the next expected event.
   always @(negedge clk) begin
      if (mon_en) begin
         if (a_err) observe(EV_ERR, int'(a_err_cnt));
         if (a_lock != lock_prev) observe(a_lock ? EV_RISE : EV_FALL, int'(a_err_cnt));
         lock_prev = a_lock;
      end
   end

   task automatic send_a(input bit flip, input bit rise);
      logic g;
      @(negedge clk);
      g       = ga[8] ^ ga[4];
      ga      = {ga[7:0], g};
      a_valid = 1'b1;
      a_bit   = g ^ flip;
      if (flip) begin
         a_errs++;
         push(EV_ERR, cyc + 1, a_errs);
      end
      if (rise) push(EV_RISE, cyc + 1, -1);
   endtask

   task automatic send_b(input bit flip);
      logic g;
      @(negedge clk);
      g       = gb[8] ^ gb[4];
      gb      = {gb[7:0], g};
      b_valid = 1'b1;
      b_bit   = g ^ flip;
   endtask

   task automatic idle();
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; a_en = 1'b1; a_valid = 1'b0; a_bit = 1'b0;
      b_en = 1'b0; b_valid = 1'b0; b_bit = 1'b0;
      ga = 9'h1FF; gb = 9'h1FF; a_errs = 0; mon_en = 1'b0; lock_prev = 1'b0;
      #1;
      check("reset_lock", a_lock, 0);
      check("reset_err", a_err, 0);
      check("reset_bit_cnt", a_bit_cnt, 0);
      check("reset_err_cnt", a_err_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;

      // Clean lock: rise after the 25th strobe, then 1000 counted bits.
      for (int i = 1; i <= 25; i++) send_a(1'b0, i == 25);
      for (int i = 0; i < 1000; i++) send_a(1'b0, 1'b0);
      idle();
      check("clean_bit_cnt", a_bit_cnt, 1000);
      check("clean_err_cnt", a_err_cnt, 0);
      check("clean_lock", a_lock, 1);

      // Three isolated errors keep lock.
      for (int i = 0; i < 100; i++) send_a(i == 10 || i == 40 || i == 80, 1'b0);
      idle();
      check("iso_err_cnt", a_err_cnt, 3);
      check("iso_bit_cnt", a_bit_cnt, 1100);
      check("iso_lock", a_lock, 1);

      // Align to a window boundary (1152 locked bits), then 8 errors, the last on the window's final bit.
      for (int i = 0; i < 52; i++) send_a(1'b0, 1'b0);
      for (int i = 0; i < 64; i++) begin
         send_a((i < 63 && i % 9 == 0) || i == 63, 1'b0);
         if (i == 63) push(EV_FALL, cyc + 1, -1);
      end
      for (int i = 1; i <= 25; i++) send_a(1'b0, i == 25);
      idle();
      check("loss_err_cnt", a_err_cnt, 11);
      check("loss_bit_cnt", a_bit_cnt, 1216);
      check("relock_lock", a_lock, 1);

      // Asynchronous reset mid-cycle while locked.
      @(posedge clk);
      #2;
      push(EV_FALL, cyc, -1);
      rst = 1'b1;
      #1;
      check("areset_lock", a_lock, 0);
      check("areset_err", a_err, 0);
      check("areset_bit_cnt", a_bit_cnt, 0);
      check("areset_err_cnt", a_err_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      a_errs = 0;
      for (int i = 1; i <= 25; i++) send_a(1'b0, i == 25);
      for (int i = 0; i < 10; i++) send_a(1'b0, 1'b0);
      idle();
      check("post_reset_bit_cnt", a_bit_cnt, 10);
      check("post_reset_lock", a_lock, 1);

      // Enable drop while locked: cleared at the next edge, strobe ignored.
      @(negedge clk);
      a_en = 1'b0; a_valid = 1'b1; a_bit = 1'b1;
      push(EV_FALL, cyc + 1, -1);
      @(negedge clk);
      a_valid = 1'b0;
      check("en_lock", a_lock, 0);
      check("en_err", a_err, 0);
      check("en_bit_cnt", a_bit_cnt, 0);
      check("en_err_cnt", a_err_cnt, 0);

      // All-zero link must never lock.
      a_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         a_valid = 1'b1;
         a_bit   = 1'b0;
      end
      idle();
      check("zero_lock", a_lock, 0);
      check("zero_bit_cnt", a_bit_cnt, 0);
      check("zero_err_cnt", a_err_cnt, 0);

      // Clean re-enable then normal relock.
      @(negedge clk);
      a_en = 1'b0;
      @(negedge clk);
      a_en = 1'b1;
      for (int i = 1; i <= 25; i++) send_a(1'b0, i == 25);
      idle();
      check("final_lock", a_lock, 1);

      // Narrow counters saturate at 15.
      @(negedge clk);
      b_en = 1'b1;
      for (int i = 0; i < 25; i++) send_b(1'b0);
      idle();
      check("sat_lock", b_lock, 1);
      check("sat_bit_cnt_start", b_bit_cnt, 0);
      for (int i = 0; i < 20; i++) send_b(1'b1);
      idle();
      check("sat_bit_cnt", b_bit_cnt, 15);
      check("sat_err_cnt", b_err_cnt, 15);
      check("sat_lock_hold", b_lock, 1);

      repeat (3) @(negedge clk);
      check("events_pending", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
